// File: rtl/mul4_scorer_pkg.sv
// rtl/mul4_scorer_pkg.sv - shared constants, state type and LFSR step for the multiplier scorer
package mul4_scorer_pkg;

   localparam int LIMB_W = 16;
   localparam int VEC_W  = 4 * LIMB_W;

   // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59
   localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
   localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0F0F_1234_5678;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mul4_vector_scorer_popcount64.sv
// rtl/mul4_vector_scorer_popcount64.sv - combinational 64-bit population count
module popcount64
   import mul4_scorer_pkg::*;
(
   input  logic [VEC_W-1:0] data,
   output logic [6:0]       count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < VEC_W; i++) begin
         count = count + {6'd0, data[i]};
      end
   end

endmodule

// File: rtl/mul4_vector_scorer.sv
// rtl/mul4_vector_scorer.sv - drives LFSR operand vectors into a multiplier candidate and scores its results
module mul4_vector_scorer #(
   parameter int          LIMB_W       = 16,
   parameter int          NUM_VECTORS  = 256,
   parameter logic [63:0] DEFAULT_SEED = 64'hACE1_0F0F_1234_5678,
   parameter int          SCORE_W      = $clog2(NUM_VECTORS * 4 * LIMB_W + 1),
   parameter int          CNT_W        = $clog2(NUM_VECTORS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*LIMB_W-1:0]   seed,
   output logic [LIMB_W-1:0]     a1,
   output logic [LIMB_W-1:0]     a0,
   output logic [LIMB_W-1:0]     b1,
   output logic [LIMB_W-1:0]     b0,
   input  logic [LIMB_W-1:0]     y3,
   input  logic [LIMB_W-1:0]     y2,
   input  logic [LIMB_W-1:0]     y1,
   input  logic [LIMB_W-1:0]     y0,
   output logic                  busy,
   output logic                  done,
   output logic [SCORE_W-1:0]    score,
   output logic [CNT_W-1:0]      exact_count
);

   import mul4_scorer_pkg::*;

   localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

   state_t               state;
   logic [63:0]          lfsr;
   logic [63:0]          lfsr_step;
   logic [63:0]          seed_eff;
   logic [4*LIMB_W-1:0]  ops;
   logic [CNT_W-1:0]     vec_cnt;
   logic [4*LIMB_W-1:0]  golden;
   logic [4*LIMB_W-1:0]  match;
   logic [6:0]           pop;
   logic                 s1_valid;
   logic                 s1_all;
   logic [6:0]           s1_pop;

   assign {a1, a0, b1, b0} = ops;

   assign golden   = (4*LIMB_W)'({a1, a0}) * (4*LIMB_W)'({b1, b0});
   assign match    = ~({y3, y2, y1, y0} ^ golden);
   assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
   assign lfsr_step = lfsr_next(lfsr);

   popcount64 u_popcount (
      .data  (match),
      .count (pop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lfsr        <= DEFAULT_SEED;
         ops         <= '0;
         vec_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         score       <= '0;
         exact_count <= '0;
         s1_valid    <= 1'b0;
         s1_all      <= 1'b0;
         s1_pop      <= '0;
      end else begin
         s1_valid <= (state == RUN);
         s1_pop   <= pop;
         s1_all   <= &match;

         if (s1_valid) begin
            score <= score + SCORE_W'(s1_pop);
            if (s1_all) begin
               exact_count <= exact_count + CNT_W'(1);
            end
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  lfsr        <= seed_eff;
                  ops         <= seed_eff;
                  vec_cnt     <= '0;
                  score       <= '0;
                  exact_count <= '0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               lfsr    <= lfsr_step;
               vec_cnt <= vec_cnt + CNT_W'(1);
               // The last vector stays on the operand bus through DRAIN and DONE
               if (vec_cnt == LAST_VEC) begin
                  state <= DRAIN;
               end else begin
                  ops <= lfsr_step;
               end
            end
            DRAIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul4_vector_scorer.sv
// tb/tb_mul4_vector_scorer.sv - scoreboard bench: a 256-vector and a 1-vector scorer with behavioural candidates
module tb_mul4_vector_scorer;

   localparam int NB  = 256;
   localparam int NS  = 1;
   localparam int SWB = $clog2(NB * 64 + 1);
   localparam int CWB = $clog2(NB + 1);
   localparam int SWS = $clog2(NS * 64 + 1);
   localparam int CWS = $clog2(NS + 1);
   localparam logic [63:0] DEF_SEED = 64'hACE1_0F0F_1234_5678;

   typedef struct {
      int score;
      int exact;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t q_b[$];
   exp_t q_s[$];

   logic            rst_b, start_b, busy_b, done_b;
   logic [63:0]     seed_b;
   logic [15:0]     a1_b, a0_b, b1_b, b0_b, y3_b, y2_b, y1_b, y0_b;
   logic [SWB-1:0]  score_b;
   logic [CWB-1:0]  exact_b;
   int              mode_b = 0;

   logic            rst_s, start_s, busy_s, done_s;
   logic [63:0]     seed_s;
   logic [15:0]     a1_s, a0_s, b1_s, b0_s, y3_s, y2_s, y1_s, y0_s;
   logic [SWS-1:0]  score_s;
   logic [CWS-1:0]  exact_s;
   int              mode_s = 0;

   // Candidate modes: 0 exact multiplier, 1 all zero, 2 all ones, 3 exact with bit 0 flipped
   function automatic logic [63:0] cand(input int mode, input logic [63:0] ops);
      logic [63:0] g;
      g = {32'd0, ops[63:32]} * {32'd0, ops[31:0]};
      case (mode)
         1:       return 64'd0;
         2:       return '1;
         3:       return g ^ 64'd1;
         default: return g;
      endcase
   endfunction

   function automatic logic [63:0] model_next(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

   always_comb {y3_b, y2_b, y1_b, y0_b} = cand(mode_b, {a1_b, a0_b, b1_b, b0_b});
   always_comb {y3_s, y2_s, y1_s, y0_s} = cand(mode_s, {a1_s, a0_s, b1_s, b0_s});

   mul4_vector_scorer #(.NUM_VECTORS(NB)) u_big (
      .clk(clk), .rst(rst_b), .start(start_b), .seed(seed_b),
      .a1(a1_b), .a0(a0_b), .b1(b1_b), .b0(b0_b),
      .y3(y3_b), .y2(y2_b), .y1(y1_b), .y0(y0_b),
      .busy(busy_b), .done(done_b), .score(score_b), .exact_count(exact_b)
   );

   mul4_vector_scorer #(.NUM_VECTORS(NS)) u_small (
      .clk(clk), .rst(rst_s), .start(start_s), .seed(seed_s),
      .a1(a1_s), .a0(a0_s), .b1(b1_s), .b0(b0_s),
      .y3(y3_s), .y2(y2_s), .y1(y1_s), .y0(y0_s),
      .busy(busy_s), .done(done_s), .score(score_s), .exact_count(exact_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic pd_b = 1'b0;
   always @(negedge clk) begin : mon_big
      exp_t e;
      if (done_b === 1'b1 && !pd_b) begin
         if (q_b.size() == 0) begin
            check("big unexpected done", 64'd1, 64'd0);
         end else begin
            e = q_b.pop_front();
            check("big score", 64'(score_b), 64'(e.score));
            check("big exact_count", 64'(exact_b), 64'(e.exact));
            check("big done cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      pd_b = (done_b === 1'b1);
   end

   logic pd_s = 1'b0;
   always @(negedge clk) begin : mon_small
      exp_t e;
      if (done_s === 1'b1 && !pd_s) begin
         if (q_s.size() == 0) begin
            check("small unexpected done", 64'd1, 64'd0);
         end else begin
            e = q_s.pop_front();
            check("small score", 64'(score_s), 64'(e.score));
            check("small exact_count", 64'(exact_s), 64'(e.exact));
            check("small done cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      pd_s = (done_s === 1'b1);
   end

   // rst_at >= 0 aborts the run with a reset at that vector index; no result is expected then
   task automatic run_big(input logic [63:0] seed, input int mode, input int exp_score,
                          input int exp_exact, input int pulse_at, input int rst_at);
      logic [63:0] m;
      int guard;
      mode_b = mode;
      @(negedge clk);
      seed_b  = seed;
      start_b = 1'b1;
      if (rst_at < 0) q_b.push_back('{exp_score, exp_exact, cyc + NB + 2});
      @(posedge clk);
      #1 start_b = 1'b0;
      m = (seed == 64'd0) ? DEF_SEED : seed;
      for (int k = 0; k < NB; k++) begin
         @(negedge clk);
         if (k == rst_at) begin
            rst_b = 1'b1;
            @(negedge clk);
            rst_b = 1'b0;
            check("rst busy", 64'(busy_b), 64'd0);
            check("rst done", 64'(done_b), 64'd0);
            check("rst score", 64'(score_b), 64'd0);
            check("rst exact_count", 64'(exact_b), 64'd0);
            check("rst operands", {a1_b, a0_b, b1_b, b0_b}, 64'd0);
            return;
         end
         check("big operands", {a1_b, a0_b, b1_b, b0_b}, m);
         check("big busy in run", 64'(busy_b), 64'd1);
         check("big done low in run", 64'(done_b), 64'd0);
         start_b = (k == pulse_at);
         m = model_next(m);
      end
      start_b = 1'b0;
      guard = 0;
      while (q_b.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (q_b.size() != 0) begin
         check("big done timeout", 64'd1, 64'd0);
         q_b.delete();
      end
      @(negedge clk);
      check("big done held", 64'(done_b), 64'd1);
      check("big busy after done", 64'(busy_b), 64'd0);
   endtask

   task automatic run_small(input logic [63:0] seed, input int mode, input int exp_score,
                            input int exp_exact, input logic [63:0] first_vec);
      int guard;
      mode_s = mode;
      @(negedge clk);
      seed_s  = seed;
      start_s = 1'b1;
      q_s.push_back('{exp_score, exp_exact, cyc + NS + 2});
      @(posedge clk);
      #1 start_s = 1'b0;
      @(negedge clk);
      check("small first vector", {a1_s, a0_s, b1_s, b0_s}, first_vec);
      guard = 0;
      while (q_s.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (q_s.size() != 0) begin
         check("small done timeout", 64'd1, 64'd0);
         q_s.delete();
      end
      check("small operands hold", {a1_s, a0_s, b1_s, b0_s}, first_vec);
   endtask

   initial begin
      rst_b = 1'b1; start_b = 1'b0; seed_b = '0;
      rst_s = 1'b1; start_s = 1'b0; seed_s = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset big busy", 64'(busy_b), 64'd0);
      check("reset big done", 64'(done_b), 64'd0);
      check("reset big score", 64'(score_b), 64'd0);
      check("reset big exact", 64'(exact_b), 64'd0);
      check("reset big operands", {a1_b, a0_b, b1_b, b0_b}, 64'd0);
      check("reset small operands", {a1_s, a0_s, b1_s, b0_s}, 64'd0);
      check("reset small done", 64'(done_s), 64'd0);
      rst_b = 1'b0;
      rst_s = 1'b0;

      run_big(64'h1, 0, 16384, 256, -1, -1);
      run_big(64'h1, 0, 16384, 256, 10, -1);
      run_big(64'h1, 0, 0, 0, -1, 50);
      run_big(64'h1, 0, 16384, 256, -1, -1);
      run_big(64'h1234_5678_9ABC_DEF0, 3, 16128, 0, -1, -1);

      run_small(64'h0000_0001_0000_0001, 1, 63, 0, 64'h0000_0001_0000_0001);
      run_small(64'h0, 0, 64, 1, DEF_SEED);
      run_small(64'h0000_0002_0000_0003, 2, 2, 0, 64'h0000_0002_0000_0003);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
